frame_decrypt_seq: RTL
======================

# frame_decrypt_seq

Sequential, handshaked decryption engine that turns one 78-bit encrypted frame back into the 60-bit raw payload. It is the receive-side counterpart of the frame encrypter: the encrypter applies four keyed rounds and prepends salt and checksum; this block strips them, undoes the four rounds one per clock, and flags checksum mismatches. It sits between the encrypted-data source and the raw-data consumer in the solver datapath.

## Interface

- `RAW_W`, default 60, width of the raw payload; fixed by the frame format.
- `ENC_W`, default 78, width of the encrypted frame: `RAW_W` + 6 salt + 12 checksum.
- `Clk` input 1: single clock; all state changes on its rising edge.
- `Rst` input 1: asynchronous, active-high reset.
- `key_60` input 60: password word; sampled only on input handshake.
- `in_valid` input 1: `data_enc_78` holds a frame.
- `in_ready` output 1: engine idle and able to accept a frame.
- `data_enc_78` input 78: frame laid out as {salt[77:72], chk[71:60], body[59:0]}.
- `out_valid` output 1: `data_raw_60` and `chk_err` are valid.
- `out_ready` input 1: consumer accepts the result.
- `data_raw_60` output 60: recovered plaintext.
- `chk_err` output 1: recomputed checksum differs from the frame's `chk`.
- `busy` output 1: high in any state other than IDLE.

## Operation

- Encryption round r (r = 1..4): body = rotl(body ^ K_r, S_r).
- Decrypt round r (applied r = 4, 3, 2, 1): body = rotr(body, S_r) ^ K_r.
- S_r: 7, 14, 21, 28. Rotations are modulo 60.
- K_r = rotl(key, 15·r) ^ {10{salt}}, using the key and salt latched at acceptance.
- Checksum: XOR of the five 12-bit slices of the 60-bit plaintext, i.e. [11:0] ^ [23:12] ^ … ^ [59:48].
- FSM states:
  - IDLE: `in_ready`=1. On `in_valid`, latch body, salt, chk and key; set round counter to 4; go to ROUND.
  - ROUND: apply decrypt round r = counter and decrement the counter. After the r = 1 round, go to CHECK.
  - CHECK: register the recomputed checksum compare into `chk_err`; go to DONE.
  - DONE: `out_valid`=1. Outputs are held stable. On `out_ready`, go to IDLE.
- `chk_err` is informational only: the payload is still delivered when it is set.
- `in_valid` outside IDLE is ignored. Input data does not need to be held after acceptance.

## Timing

- Reset (asynchronous, any state):
  - FSM goes to IDLE.
  - `in_ready`=1 once reset is released.
  - `out_valid`, `busy` and `chk_err` are 0.
  - `data_raw_60` is 0.
  - The round counter is 0.
  - Any in-flight frame is discarded.
- Latency: handshake at edge T; rounds at edges T+1..T+4; CHECK at T+5; `out_valid` is high from just after T+5.
- In-flight period: `in_ready` is 0 from T until one edge after the output handshake.
- Throughput: at most one frame per 7 cycles when `out_ready` is held high.
- Backpressure: `out_valid` stays high and `data_raw_60`/`chk_err` stay constant until the `out_ready` handshake.
- Both valid and ready high in the same cycle is a handshake. On the output side, `in_ready` rises the following cycle, never combinationally.
- `out_valid` has no combinational dependence on `out_ready`.

## Structure

- Shared package `crypt_pkg`:
  - `RAW_W`, `ENC_W`, `SALT_W`=6, `CHK_W`=12.
  - Shift table S_r.
  - Key-schedule function K(key, salt, r).
  - Checksum function.
  - FSM state enum.
- The encrypter reuses the same package.
- Sub-module `dec_round`: combinational single inverse round, with inputs body, key, salt and r, and output the next body. It is instantiated once and time-multiplexed by the round counter.

## Test plan

- Zero vector: key=0, frame 78'h0 → `out_valid` after 6 edges, `data_raw_60`=0, `chk_err`=0.
- Known vector: key=0, frame {6'h00, 12'h001, 60'h400} → `data_raw_60`=60'h1, `chk_err`=0.
- Bad checksum: the same frame with chk=12'h000 → `data_raw_60`=60'h1, `chk_err`=1.
- Backpressure: hold `out_ready`=0 for 3 cycles after `out_valid` → outputs constant and `in_ready`=0 throughout; `in_ready`=1 one cycle after the handshake.
- Back-to-back:
  - Two frames offered continuously with `out_ready`=1 → second accepted exactly 7 edges after the first.
  - Results match a reference model across 1,000 random keys, salts and plaintexts encrypted per Operation.
- Reset mid-operation: assert `Rst` during ROUND with counter = 2 → `out_valid`=0, `busy`=0 and `data_raw_60`=0 immediately; next frame decrypts correctly.

Source files
------------

// File: rtl/crypt_pkg.sv
// Shared definitions for the frame encrypter/decrypter pair: frame geometry,
// round shift table, key schedule, payload checksum and the engine FSM states.
package crypt_pkg;

   localparam int RAW_W  = 60;
   localparam int SALT_W = 6;
   localparam int CHK_W  = 12;
   localparam int ENC_W  = RAW_W + SALT_W + CHK_W;
   localparam int ROUNDS = 4;

   typedef logic [RAW_W-1:0]  word_t;
   typedef logic [SALT_W-1:0] salt_t;
   typedef logic [CHK_W-1:0]  chk_t;
   typedef logic [2:0]        round_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ROUND,
      ST_CHECK,
      ST_DONE
   } state_t;

   // Round shift S_r; round 0 never reaches the datapath output.
   function automatic int shift_of(round_t r);
      case (r)
         3'd1:    return 7;
         3'd2:    return 14;
         3'd3:    return 21;
         3'd4:    return 28;
         default: return 0;
      endcase
   endfunction

   function automatic word_t rotl(word_t x, int s);
      logic [2*RAW_W-1:0] d;
      d = {x, x} << (s % RAW_W);
      return d[2*RAW_W-1:RAW_W];
   endfunction

   function automatic word_t rotr(word_t x, int s);
      logic [2*RAW_W-1:0] d;
      d = {x, x} >> (s % RAW_W);
      return d[RAW_W-1:0];
   endfunction

   function automatic word_t key_sched(word_t key, salt_t salt, round_t r);
      return rotl(key, 15 * int'(r)) ^ {(RAW_W/SALT_W){salt}};
   endfunction

   function automatic chk_t checksum(word_t x);
      chk_t c;
      c = '0;
      for (int i = 0; i < RAW_W/CHK_W; i++) begin
         c = c ^ x[i*CHK_W +: CHK_W];
      end
      return c;
   endfunction

endpackage

// File: rtl/dec_round.sv
// One inverse encryption round: rotate right by S_r, then strip the round key.
module dec_round
   import crypt_pkg::*;
(
   input  word_t  body_i,
   input  word_t  key_i,
   input  salt_t  salt_i,
   input  round_t round_i,
   output word_t  body_o
);

   assign body_o = rotr(body_i, shift_of(round_i)) ^ key_sched(key_i, salt_i, round_i);

endmodule

// File: rtl/frame_decrypt_seq.sv
// Handshaked frame decrypter: accepts a salted, checksummed frame, undoes the
// four keyed rounds one per clock and reports the payload with a checksum flag.
module frame_decrypt_seq #(
   parameter int RAW_W = 60,
   parameter int ENC_W = 78
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic [RAW_W-1:0] key_60,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [ENC_W-1:0] data_enc_78,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [RAW_W-1:0] data_raw_60,
   output logic             chk_err,
   output logic             busy
);
   import crypt_pkg::*;

   state_t           state_q;
   round_t           cnt_q;
   logic [RAW_W-1:0] body_q;
   logic [RAW_W-1:0] body_d;
   logic [RAW_W-1:0] key_q;
   salt_t            salt_q;
   chk_t             chk_q;
   logic [RAW_W-1:0] data_q;
   logic             chk_err_q;
   logic             in_ready_q;
   logic             out_valid_q;
   logic             busy_q;

   // Single round datapath, stepped through r = 4..1 by the counter.
   dec_round u_round (
      .body_i  (body_q),
      .key_i   (key_q),
      .salt_i  (salt_q),
      .round_i (cnt_q),
      .body_o  (body_d)
   );

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         body_q      <= '0;
         key_q       <= '0;
         salt_q      <= '0;
         chk_q       <= '0;
         data_q      <= '0;
         chk_err_q   <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid) begin
                  body_q     <= data_enc_78[RAW_W-1:0];
                  chk_q      <= data_enc_78[RAW_W +: CHK_W];
                  salt_q     <= data_enc_78[ENC_W-1 -: SALT_W];
                  key_q      <= key_60;
                  cnt_q      <= round_t'(ROUNDS);
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
                  state_q    <= ST_ROUND;
               end
            end
            ST_ROUND: begin
               body_q <= body_d;
               cnt_q  <= cnt_q - 3'd1;
               if (cnt_q == 3'd1) begin
                  state_q <= ST_CHECK;
               end
            end
            ST_CHECK: begin
               // The payload is delivered even when the checksum disagrees.
               data_q      <= body_q;
               chk_err_q   <= (checksum(body_q) != chk_q);
               out_valid_q <= 1'b1;
               state_q     <= ST_DONE;
            end
            ST_DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  busy_q      <= 1'b0;
                  state_q     <= ST_IDLE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               busy_q      <= 1'b0;
               state_q     <= ST_IDLE;
            end
         endcase
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = out_valid_q;
   assign busy        = busy_q;
   assign data_raw_60 = data_q;
   assign chk_err     = chk_err_q;

endmodule
